// File: rtl/io_interrupt_controller_if.sv
// ---------------------------------------------------------------------------
// io_interrupt_controller_if
//   IO-port register bus plus the interrupt request lines that the
//   controller drives back toward the system bus. The CPU/bus side uses the
//   master modport, the controller uses the slave modport.
// ---------------------------------------------------------------------------
interface io_interrupt_controller_if;
  logic [31:0] io_addr;
  logic [31:0] io_write_data;
  logic        io_write_en;
  logic [31:0] io_read_data;
  logic        io_interrupt;
  logic [4:0]  io_interrupt_id;

  modport master (
    output io_addr,
    output io_write_data,
    output io_write_en,
    input  io_read_data,
    input  io_interrupt,
    input  io_interrupt_id
  );

  modport slave (
    input  io_addr,
    input  io_write_data,
    input  io_write_en,
    output io_read_data,
    output io_interrupt,
    output io_interrupt_id
  );
endinterface

// File: rtl/io_interrupt_controller.sv
// ---------------------------------------------------------------------------
// io_interrupt_controller
//   Collects up to 32 peripheral IRQ lines, arbitrates with fixed priority
//   (lowest index wins) and presents one interrupt at a time to the bus.
//   The CPU claims and completes the interrupt through register writes.
//
//   Register window (offset = io_addr[7:0], window hit on io_addr[31:8]):
//     0x00 PENDING  RO/W1C   0x04 ENABLE   RW   0x08 EDGE_SEL RW (1=rising)
//     0x0C STATUS   RO       0x10 CLAIM    WO   0x14 COMPLETE WO
//
//   Optional feature macro: IRQ_SYNC_EN
//     defined   : each irq_src bit passes a 2-flop synchronizer first
//     undefined : irq_src is sampled directly (must be synchronous to clk)
// ---------------------------------------------------------------------------
module io_interrupt_controller #(
  parameter int          NUM_SOURCES = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] irq_src,
  io_interrupt_controller_if.slave bus
);

  localparam logic [31:0] IMPL_MASK = (NUM_SOURCES >= 32) ? 32'hFFFF_FFFF
                                    : ((32'd1 << NUM_SOURCES) - 32'd1);

  localparam logic [7:0] OFF_PENDING  = 8'h00;
  localparam logic [7:0] OFF_ENABLE   = 8'h04;
  localparam logic [7:0] OFF_EDGE_SEL = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_CLAIM    = 8'h10;
  localparam logic [7:0] OFF_COMPLETE = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ASSERT     = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_t;

  state_t      state_q;
  logic        irq_q;
  logic [4:0]  id_q;

  logic [31:0] pending_q;
  logic [31:0] enable_q;
  logic [31:0] edge_sel_q;
  logic [31:0] prev_q;

  logic [NUM_SOURCES-1:0] s_raw;
  logic [31:0] s_ext;
  logic [31:0] rise;
  logic [31:0] clr;
  logic [31:0] pending_d;
  logic [31:0] req;
  logic [4:0]  win;

  logic        hit;
  logic [7:0]  off;
  logic        wr_pending;
  logic        wr_enable;
  logic        wr_edge_sel;
  logic        wr_claim;
  logic        wr_complete;
  logic [4:0]  wr_id;
  logic        claim_ok;
  logic        complete_ok;

  // -------------------------------------------------------------------------
  // Source sampling path
  // -------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
  logic [NUM_SOURCES-1:0] sync_q1;
  logic [NUM_SOURCES-1:0] sync_q2;

  // Two-flop synchronizer per line; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign s_raw = sync_q2;
`else
  assign s_raw = irq_src;
`endif

  // Zero-extend the sampled lines to the 32-bit register width.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    s_ext = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      s_ext[i] = s_raw[i];
    end
  end

  // -------------------------------------------------------------------------
  // Register decode
  // -------------------------------------------------------------------------
  // Address decode and write strobes; claim/complete only act on a match.
  always_comb begin
    hit         = (bus.io_addr[31:8] == BASE_ADDR[31:8]);
    off         = bus.io_addr[7:0];
    wr_pending  = bus.io_write_en && hit && (off == OFF_PENDING);
    wr_enable   = bus.io_write_en && hit && (off == OFF_ENABLE);
    wr_edge_sel = bus.io_write_en && hit && (off == OFF_EDGE_SEL);
    wr_claim    = bus.io_write_en && hit && (off == OFF_CLAIM);
    wr_complete = bus.io_write_en && hit && (off == OFF_COMPLETE);
    wr_id       = bus.io_write_data[4:0];
    claim_ok    = wr_claim    && (state_q == ST_ASSERT)     && (wr_id == id_q);
    complete_ok = wr_complete && (state_q == ST_IN_SERVICE) && (wr_id == id_q);
  end

  // Combinational read mux; misses and write-only offsets read zero.
  always_comb begin
    bus.io_read_data = '0;
    if (hit) begin
      case (off)
        OFF_PENDING:  bus.io_read_data = pending_q;
        OFF_ENABLE:   bus.io_read_data = enable_q;
        OFF_EDGE_SEL: bus.io_read_data = edge_sel_q;
        // Bit 31 flags an outstanding unclaimed request, bit 30 in-service.
        OFF_STATUS:   bus.io_read_data = {(state_q == ST_ASSERT),
                                          (state_q == ST_IN_SERVICE),
                                          25'b0, id_q};
        default:      bus.io_read_data = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Pending logic and arbitration
  // -------------------------------------------------------------------------
  // Next PENDING: level sources mirror the line, edge sources latch rising
  // edges and clear on W1C or an accepted claim, with set winning over clear.
  always_comb begin
    rise = s_ext & ~prev_q;
    clr  = (wr_pending ? bus.io_write_data : 32'd0)
         | (claim_ok   ? (32'd1 << id_q)   : 32'd0);
    pending_d = '0;
    for (int i = 0; i < 32; i++) begin
      if (!IMPL_MASK[i]) begin
        pending_d[i] = 1'b0;
      end else if (edge_sel_q[i]) begin
        pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
      end else begin
        pending_d[i] = s_ext[i];
      end
    end
  end

  // Fixed priority: scanning downward leaves the lowest requesting index.
  always_comb begin
    req = pending_q & enable_q;
    win = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (req[i]) win = 5'(i);
    end
  end

  // Configuration/pending registers and the previous-sample tracker.
  always_ff @(posedge clk) begin
    // NOTE: all state here is ordinary flops (no memory arrays), so every
    // register is cleared by the synchronous reset.
    if (!rst_n) begin
      pending_q  <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
      prev_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state so every
      // flop samples pre-edge values regardless of statement order.
      prev_q    <= s_ext;
      pending_q <= pending_d;
      if (wr_enable)   enable_q   <= bus.io_write_data & IMPL_MASK;
      if (wr_edge_sel) edge_sel_q <= bus.io_write_data & IMPL_MASK;
    end
  end

  // -------------------------------------------------------------------------
  // Interrupt FSM
  // -------------------------------------------------------------------------
  // IDLE -> ASSERT -> IN_SERVICE -> IDLE with registered request and id.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            id_q    <= win;
            irq_q   <= 1'b1;
            state_q <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          // A matching claim takes precedence over a same-cycle withdrawal.
          if (claim_ok) begin
            irq_q   <= 1'b0;
            state_q <= ST_IN_SERVICE;
          end else if (!req[id_q]) begin
            irq_q   <= 1'b0;
            id_q    <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_IN_SERVICE: begin
          if (complete_ok) begin
            id_q    <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          id_q    <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.io_interrupt    = irq_q;
  assign bus.io_interrupt_id = id_q;

endmodule

// File: tb/tb_io_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_io_interrupt_controller
//   Directed vectors for io_interrupt_controller with hand-computed
//   expectations. Timing adapts to the IRQ_SYNC_EN build via LAT_EXTRA.
// ---------------------------------------------------------------------------
module tb_io_interrupt_controller;

`ifdef IRQ_SYNC_EN
  localparam int LAT_EXTRA = 2;
`else
  localparam int LAT_EXTRA = 0;
`endif

  localparam logic [31:0] A_PENDING  = 32'h0000_1000;
  localparam logic [31:0] A_ENABLE   = 32'h0000_1004;
  localparam logic [31:0] A_EDGE_SEL = 32'h0000_1008;
  localparam logic [31:0] A_STATUS   = 32'h0000_100C;
  localparam logic [31:0] A_CLAIM    = 32'h0000_1010;
  localparam logic [31:0] A_COMPLETE = 32'h0000_1014;

  logic        clk;
  logic        rst_n;
  logic [31:0] irq_src;
  logic [31:0] rd;
  int          n_vec;
  int          n_bad;

  io_interrupt_controller_if bus_if ();

  io_interrupt_controller #(
    .NUM_SOURCES(32),
    .BASE_ADDR  (32'h0000_1000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_src(irq_src),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.io_addr       = addr;
    bus_if.io_write_data = data;
    bus_if.io_write_en   = 1'b1;
    tick();
    bus_if.io_write_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_if.io_addr     = addr;
    bus_if.io_write_en = 1'b0;
    #1;
    data = bus_if.io_read_data;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp);
    logic [31:0] v;
    bus_read(addr, v);
    check(tag, v, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp_irq,
                           input logic [4:0] exp_id);
    check({tag, "_irq"}, 32'(bus_if.io_interrupt),    32'(exp_irq));
    check({tag, "_id"},  32'(bus_if.io_interrupt_id), 32'(exp_id));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    bus_if.io_addr       = '0;
    bus_if.io_write_data = '0;
    bus_if.io_write_en   = 1'b0;
    irq_src = 32'hFFFF_FFFF;
    rst_n   = 1'b0;
    rd      = '0;

    // Reset with every line high and nothing enabled.
    settle(3);
    check_irq("reset", 1'b0, 5'd0);
    check_reg("reset_pending",  A_PENDING,  32'h0);
    check_reg("reset_enable",   A_ENABLE,   32'h0);
    check_reg("reset_edge_sel", A_EDGE_SEL, 32'h0);
    check_reg("reset_status",   A_STATUS,   32'h0);
    rst_n   = 1'b1;
    irq_src = '0;
    settle(2 + LAT_EXTRA);

    // Edge source 3: single-cycle pulse, claim, complete.
    bus_write(A_EDGE_SEL, 32'h0000_0008);
    bus_write(A_ENABLE,   32'h0000_0008);
    irq_src[3] = 1'b1;
    tick();
    irq_src = '0;
    settle(LAT_EXTRA);
    check("edge3_not_yet", 32'(bus_if.io_interrupt), 32'd0);
    tick();
    check_irq("edge3_assert", 1'b1, 5'd3);
    check_reg("edge3_pending", A_PENDING, 32'h0000_0008);
    bus_write(A_CLAIM, 32'd3);
    check_irq("edge3_claim", 1'b0, 5'd3);
    check_reg("edge3_claim_status",  A_STATUS,  32'h4000_0003);
    check_reg("edge3_claim_pending", A_PENDING, 32'h0);
    bus_write(A_COMPLETE, 32'd3);
    check_reg("edge3_done_status", A_STATUS, 32'h0);
    check_irq("edge3_done", 1'b0, 5'd0);

    // Level sources 2 and 5: priority, mismatched claim, re-assert after complete.
    bus_write(A_EDGE_SEL, 32'h0);
    bus_write(A_ENABLE,   32'h0000_0024);
    irq_src = 32'h0000_0024;
    settle(LAT_EXTRA + 2);
    check_irq("lvl25_assert", 1'b1, 5'd2);
    check_reg("lvl25_status", A_STATUS, 32'h8000_0002);
    bus_write(A_CLAIM, 32'd5);
    check_reg("lvl25_bad_claim_status", A_STATUS, 32'h8000_0002);
    check("lvl25_bad_claim_irq", 32'(bus_if.io_interrupt), 32'd1);
    bus_write(A_CLAIM, 32'd2);
    check_reg("lvl25_claim_status", A_STATUS, 32'h4000_0002);
    check("lvl25_claim_irq", 32'(bus_if.io_interrupt), 32'd0);
    irq_src = 32'h0000_0020;
    settle(LAT_EXTRA);
    bus_write(A_COMPLETE, 32'd2);
    check_irq("lvl25_complete", 1'b0, 5'd0);
    tick();
    check_irq("lvl25_reassert", 1'b1, 5'd5);
    irq_src = '0;
    settle(LAT_EXTRA + 2);
    check_irq("lvl5_withdrawn", 1'b0, 5'd0);

    // Level source 7 drops before being claimed.
    bus_write(A_ENABLE, 32'h0000_0080);
    irq_src = 32'h0000_0080;
    settle(LAT_EXTRA + 2);
    check_irq("lvl7_assert", 1'b1, 5'd7);
    irq_src = '0;
    settle(LAT_EXTRA + 1);
    check("lvl7_still_high", 32'(bus_if.io_interrupt), 32'd1);
    tick();
    check_irq("lvl7_drop", 1'b0, 5'd0);
    check_reg("lvl7_status", A_STATUS, 32'h0);

    // Edge source 1: edge during service, re-assert, W1C races.
    bus_write(A_EDGE_SEL, 32'h0000_0002);
    bus_write(A_ENABLE,   32'h0000_0002);
    irq_src = 32'h0000_0002;
    tick();
    irq_src = '0;
    settle(LAT_EXTRA + 1);
    check_irq("edge1_assert", 1'b1, 5'd1);
    bus_write(A_CLAIM, 32'd1);
    check_reg("edge1_claim_status", A_STATUS, 32'h4000_0001);
    irq_src = 32'h0000_0002;
    tick();
    irq_src = '0;
    settle(LAT_EXTRA);
    check_reg("edge1_svc_pending", A_PENDING, 32'h0000_0002);
    check_reg("edge1_svc_status",  A_STATUS,  32'h4000_0001);
    bus_write(A_COMPLETE, 32'd1);
    check_irq("edge1_complete", 1'b0, 5'd0);
    tick();
    check_irq("edge1_reassert", 1'b1, 5'd1);
    irq_src = 32'h0000_0002;
    settle(LAT_EXTRA);
    bus_write(A_PENDING, 32'h0000_0002);
    check_reg("w1c_vs_edge_pending", A_PENDING, 32'h0000_0002);
    check("w1c_vs_edge_irq", 32'(bus_if.io_interrupt), 32'd1);
    irq_src = '0;
    settle(LAT_EXTRA);
    bus_write(A_PENDING, 32'h0000_0002);
    check_reg("w1c_pending", A_PENDING, 32'h0);
    check("w1c_irq_hold", 32'(bus_if.io_interrupt), 32'd1);
    tick();
    check_irq("w1c_withdraw", 1'b0, 5'd0);

    // Writes and reads outside the window or at unmapped offsets.
    bus_write(32'h0000_2004, 32'hFFFF_FFFF);
    check_reg("miss_write_enable", A_ENABLE, 32'h0000_0002);
    check_reg("miss_read", 32'h0000_2004, 32'h0);
    check_reg("unmapped_read", 32'h0000_1018, 32'h0);

    // Reset while in service abandons it.
    irq_src = 32'h0000_0002;
    tick();
    irq_src = '0;
    settle(LAT_EXTRA + 1);
    bus_write(A_CLAIM, 32'd1);
    check_reg("rst_svc_status", A_STATUS, 32'h4000_0001);
    rst_n = 1'b0;
    tick();
    check_irq("rst_svc", 1'b0, 5'd0);
    check_reg("rst_svc_status_after", A_STATUS, 32'h0);
    check_reg("rst_svc_enable",       A_ENABLE, 32'h0);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
